slot_router: RTL and testbench

Parametrised virtual slot controller for the A2FPGA Apple II slot bus. Holds a per-slot card table, decodes I/OSELECT, DEVSELECT and I/OSTROBE for the virtual cards, and tracks which slot owns the shared $C800–$CFFF expansion ROM window, as real Apple II cards do. Configuration writes to a slot that is currently on the bus are deferred to the end of that bus cycle. Sits between the bus front end and the card instances, feeding their per-slot selects.

---
 rtl/slot_pkg.sv | 36 +++
 rtl/slot_c8_owner.sv | 43 ++++
 rtl/slot_router.sv | 213 +++++++++++++++++++++
 tb/tb_slot_router.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// slot_pkg: shared constants, types and address-decode helpers for the
// slot_router virtual slot controller.
package slot_pkg;

  // Apple II slot I/O map anchors
  localparam logic [15:0] SLOT_IO_BASE  = 16'hC000;
  localparam logic [15:0] SLOT_DEV_BASE = 16'hC080;
  localparam logic [15:0] C8_BASE       = 16'hC800;
  localparam logic [15:0] C8_RELEASE    = 16'hCFFF;

  typedef logic [2:0] slot_idx_t;

  // Config-write deferral: idle (ready), holding a deferred write,
  // and one recovery cycle after the commit before ready returns.
  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_PENDING,
    CFG_RECOVER
  } cfg_state_t;

  // $C100-$C7FF: per-slot $Cnxx ROM page (slot 0 has no page)
  function automatic logic is_io_space(input logic [15:0] a);
    return ((a & 16'hF800) == SLOT_IO_BASE) && (a[10:8] != 3'd0);
  endfunction

  // $C090-$C0FF: per-slot 16-byte device register block
  function automatic logic is_dev_space(input logic [15:0] a);
    return ((a & 16'hFF80) == SLOT_DEV_BASE) && (a[6:4] != 3'd0);
  endfunction

  // $C800-$CFFF: shared expansion ROM window
  function automatic logic is_c8_space(input logic [15:0] a);
    return (a & 16'hF800) == C8_BASE;
  endfunction

endpackage

// File: rtl/slot_c8_owner.sv
// slot_c8_owner: tracks which slot owns the shared $C800-$CFFF window.
// Only instantiated when SLOT_ROUTER_C8_OWNER_EN is defined.
module slot_c8_owner
  import slot_pkg::*;
(
  input  logic       clk_logic,
  input  logic       reset,
  input  logic       claim_en,
  input  logic [2:0] claim_slot,
  input  logic       release_en,
  input  logic       clear_en,
  input  logic [2:0] clear_slot,
  output logic [2:0] owner_o
);

  slot_idx_t owner_q;
  slot_idx_t owner_d;

  // Claim or release first, then a card-0 write to the resulting owner wins
  always_comb begin
    owner_d = owner_q;
    if (claim_en) begin
      owner_d = claim_slot;
    end else if (release_en) begin
      owner_d = '0;
    end
    if (clear_en && (owner_d == clear_slot)) begin
      owner_d = '0;
    end
  end

  // Owner register
  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      owner_q <= '0;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/slot_router.sv
// slot_router: per-slot card table, I/OSELECT / DEVSELECT / I/OSTROBE decode
// and deferred configuration writes for the A2FPGA virtual slot bus.
// Optional feature macro: SLOT_ROUTER_C8_OWNER_EN enables $C8 window
// ownership tracking; without it I/OSTROBE is broadcast with no owner.
module slot_router
  import slot_pkg::*;
#(
  parameter int                          NUM_SLOTS  = 8,
  parameter int                          CARD_W     = 8,
  parameter logic [NUM_SLOTS*CARD_W-1:0] SLOT_CARDS = '0
) (
  input  logic              clk_logic,
  input  logic              reset,
  input  logic              phi0_i,
  input  logic [15:0]       addr_i,
  input  logic              m2sel_n_i,
  input  logic              intcxrom_i,
  input  logic              intc8rom_i,
  input  logic [2:0]        cfg_slot_i,
  input  logic              cfg_wr_i,
  input  logic [CARD_W-1:0] cfg_card_i,
  output logic              cfg_ready_o,
  output logic [CARD_W-1:0] cfg_card_o,
  output logic [2:0]        slot_sel_o,
  output logic [CARD_W-1:0] slot_card_o,
  output logic              slot_ioselect_n_o,
  output logic              slot_devselect_n_o,
  output logic              slot_iostrobe_n_o,
  output logic [2:0]        c8_owner_o
);

  // The table always has 8 entries so a 3-bit index never goes out of
  // range; entries at or above NUM_SLOTS reset to 0 and are never written.
  localparam int                PAD_W     = 8 * CARD_W;
  localparam logic [PAD_W-1:0]  CARDS_PAD = PAD_W'(SLOT_CARDS);
  localparam slot_idx_t         LAST_SLOT = slot_idx_t'(NUM_SLOTS - 1);

  logic [CARD_W-1:0] card_table [8];

  cfg_state_t        cfg_state;
  cfg_state_t        cfg_state_next;
  slot_idx_t         pend_slot;
  logic [CARD_W-1:0] pend_card;

  logic              phi0_q;
  logic              acc_q;
  logic [15:0]       addr_q;
  slot_idx_t         owner;

  logic              live;
  logic              eoc;
  logic              accept;
  logic              slot_in_range;
  logic              defer;
  logic              direct_wr;
  logic              commit;
  logic              wr_en;
  slot_idx_t         wr_slot;
  logic [CARD_W-1:0] wr_card;

  // A slot decodes only if it exists, is not slot 0, and holds a card
  function automatic logic slot_enabled(input slot_idx_t n);
    return (n != '0) && (n <= LAST_SLOT) && (card_table[n] != '0);
  endfunction

  assign live = phi0_i & ~m2sel_n_i;
  assign eoc  = phi0_q & ~phi0_i;

  // Zero-latency select decode from the bus inputs and current state
  always_comb begin
    slot_sel_o         = '0;
    slot_ioselect_n_o  = 1'b1;
    slot_devselect_n_o = 1'b1;
    slot_iostrobe_n_o  = 1'b1;
    if (live) begin
      if (is_io_space(addr_i)) begin
        if (!intcxrom_i && slot_enabled(addr_i[10:8])) begin
          slot_sel_o        = addr_i[10:8];
          slot_ioselect_n_o = 1'b0;
        end
      end else if (is_dev_space(addr_i)) begin
        if (slot_enabled(addr_i[6:4])) begin
          slot_sel_o         = addr_i[6:4];
          slot_devselect_n_o = 1'b0;
        end
      end else if (is_c8_space(addr_i) && !intcxrom_i && !intc8rom_i) begin
`ifdef SLOT_ROUTER_C8_OWNER_EN
        if (owner != '0) begin
          slot_sel_o        = owner;
          slot_iostrobe_n_o = 1'b0;
        end
`else
        slot_iostrobe_n_o = 1'b0;
`endif
      end
    end
  end

  assign slot_card_o = (slot_sel_o != '0) ? card_table[slot_sel_o] : '0;

  // A write aimed at the slot that is on the bus right now waits for the
  // end of the bus cycle so the card never sees its ID change mid-access.
  assign cfg_ready_o   = (cfg_state == CFG_IDLE);
  assign accept        = cfg_wr_i & cfg_ready_o;
  assign slot_in_range = (cfg_slot_i <= LAST_SLOT);
  assign defer         = accept & slot_in_range & (slot_sel_o != '0) &
                         (cfg_slot_i == slot_sel_o);
  assign direct_wr     = accept & slot_in_range & ~defer;
  assign commit        = (cfg_state == CFG_PENDING) & eoc;

  assign wr_en   = direct_wr | commit;
  assign wr_slot = commit ? pend_slot : cfg_slot_i;
  assign wr_card = commit ? pend_card : cfg_card_i;

  // Deferral state: next-state decode
  always_comb begin
    cfg_state_next = cfg_state;
    case (cfg_state)
      CFG_IDLE:    if (defer) cfg_state_next = CFG_PENDING;
      CFG_PENDING: if (eoc)   cfg_state_next = CFG_RECOVER;
      CFG_RECOVER: cfg_state_next = CFG_IDLE;
      default:     cfg_state_next = CFG_IDLE;
    endcase
  end

  // Deferral state register
  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      cfg_state <= CFG_IDLE;
    end else begin
      cfg_state <= cfg_state_next;
    end
  end

  // One-entry pending buffer for deferred writes
  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      pend_slot <= '0;
      pend_card <= '0;
    end else if (defer) begin
      pend_slot <= cfg_slot_i;
      pend_card <= cfg_card_i;
    end
  end

  // Card table: reloads the build-time cards on reset, else direct or committed writes
  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        card_table[i] <= CARDS_PAD[i*CARD_W +: CARD_W];
      end
    end else if (wr_en) begin
      card_table[wr_slot] <= wr_card;
    end
  end

  // Registered table read; sees the table before any same-edge write
  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      cfg_card_o <= '0;
    end else begin
      cfg_card_o <= slot_in_range ? card_table[cfg_slot_i] : '0;
    end
  end

  // Bus-cycle tracking: phase history plus the last live address
  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      phi0_q <= 1'b0;
      acc_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      phi0_q <= phi0_i;
      if (live) begin
        addr_q <= addr_i;
        acc_q  <= 1'b1;
      end else if (eoc) begin
        acc_q  <= 1'b0;
      end
    end
  end

`ifdef SLOT_ROUTER_C8_OWNER_EN
  logic claim_en;
  logic release_en;
  logic clear_en;

  // Claim uses the table as it stood before any same-edge commit
  assign claim_en   = eoc & acc_q & is_io_space(addr_q) & ~intcxrom_i &
                      slot_enabled(addr_q[10:8]);
  assign release_en = eoc & acc_q & (addr_q == C8_RELEASE);
  assign clear_en   = wr_en & (wr_card == '0);

  slot_c8_owner u_c8_owner (
    .clk_logic  (clk_logic),
    .reset      (reset),
    .claim_en   (claim_en),
    .claim_slot (addr_q[10:8]),
    .release_en (release_en),
    .clear_en   (clear_en),
    .clear_slot (wr_slot),
    .owner_o    (owner)
  );
`else
  logic unused_capture;

  assign owner          = '0;
  assign unused_capture = ^{addr_q, acc_q};
`endif

  assign c8_owner_o = owner;

endmodule

// File: tb/tb_slot_router.sv
// tb_slot_router: randomized scoreboard bench for slot_router with a
// behavioural reference model of the slot table, deferral and $C8 window.
module tb_slot_router;

  localparam int NS = 7;
  localparam int CW = 8;
  // slot 6..slot 0
  localparam logic [NS*CW-1:0] CARDS = {8'h12, 8'h00, 8'h44, 8'h33, 8'h00, 8'h21, 8'h5A};

  logic        clk_logic = 1'b0;
  logic        reset = 1'b1;
  logic        phi0_i = 1'b0;
  logic [15:0] addr_i = 16'h0000;
  logic        m2sel_n_i = 1'b1;
  logic        intcxrom_i = 1'b0;
  logic        intc8rom_i = 1'b0;
  logic [2:0]  cfg_slot_i = 3'd0;
  logic        cfg_wr_i = 1'b0;
  logic [7:0]  cfg_card_i = 8'h00;
  logic        cfg_ready_o;
  logic [7:0]  cfg_card_o;
  logic [2:0]  slot_sel_o;
  logic [7:0]  slot_card_o;
  logic        slot_ioselect_n_o;
  logic        slot_devselect_n_o;
  logic        slot_iostrobe_n_o;
  logic [2:0]  c8_owner_o;

  slot_router #(.NUM_SLOTS(NS), .CARD_W(CW), .SLOT_CARDS(CARDS)) dut (
    .clk_logic          (clk_logic),
    .reset              (reset),
    .phi0_i             (phi0_i),
    .addr_i             (addr_i),
    .m2sel_n_i          (m2sel_n_i),
    .intcxrom_i         (intcxrom_i),
    .intc8rom_i         (intc8rom_i),
    .cfg_slot_i         (cfg_slot_i),
    .cfg_wr_i           (cfg_wr_i),
    .cfg_card_i         (cfg_card_i),
    .cfg_ready_o        (cfg_ready_o),
    .cfg_card_o         (cfg_card_o),
    .slot_sel_o         (slot_sel_o),
    .slot_card_o        (slot_card_o),
    .slot_ioselect_n_o  (slot_ioselect_n_o),
    .slot_devselect_n_o (slot_devselect_n_o),
    .slot_iostrobe_n_o  (slot_iostrobe_n_o),
    .c8_owner_o         (c8_owner_o)
  );

  always #5 clk_logic = ~clk_logic;

  typedef struct {
    int rdy;
    int card_rd;
    int sel;
    int scard;
    int io_n;
    int dev_n;
    int stb_n;
    int owner;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int          m_table [8];
  int          m_owner;
  bit          m_pend;
  bit          m_rec;
  int          m_pslot;
  int          m_pcard;
  int          m_cfg_rd;
  bit          m_acc;
  int          m_cap;
  bit          m_prev_phi0;

  function automatic void model_reset();
    logic [NS*CW-1:0] cards_v;
    cards_v = CARDS;
    for (int i = 0; i < 8; i++) begin
      m_table[i] = (i < NS) ? int'(cards_v[i*CW +: CW]) : 0;
    end
    m_owner = 0; m_pend = 0; m_rec = 0; m_pslot = 0; m_pcard = 0;
    m_cfg_rd = 0; m_acc = 0; m_cap = 0; m_prev_phi0 = 0;
  endfunction

  function automatic bit slot_on(int n);
    return (n >= 1) && (n < NS) && (m_table[n] != 0);
  endfunction

  function automatic void model_decode(output int sel, output int io_n,
                                       output int dev_n, output int stb_n);
    int a;
    a = int'(addr_i);
    sel = 0; io_n = 1; dev_n = 1; stb_n = 1;
    if (phi0_i && !m2sel_n_i) begin
      if (a >= 'hC100 && a <= 'hC7FF) begin
        if (slot_on((a - 'hC000) / 256) && !intcxrom_i) begin
          sel = (a - 'hC000) / 256; io_n = 0;
        end
      end else if (a >= 'hC090 && a <= 'hC0FF) begin
        if (slot_on((a - 'hC080) / 16)) begin
          sel = (a - 'hC080) / 16; dev_n = 0;
        end
      end else if (a >= 'hC800 && a <= 'hCFFF && !intcxrom_i && !intc8rom_i) begin
`ifdef SLOT_ROUTER_C8_OWNER_EN
        if (m_owner != 0) begin
          sel = m_owner; stb_n = 0;
        end
`else
        stb_n = 0;
`endif
      end
    end
  endfunction

  // advance the model across one rising edge using the inputs held across it
  function automatic void model_edge();
    int sel, io_n, dev_n, stb_n;
    bit eoc, live, ready;
    int new_owner, wslot, wcard, rd;
    if (reset) begin
      model_reset();
      return;
    end
    model_decode(sel, io_n, dev_n, stb_n);
    eoc   = m_prev_phi0 && !phi0_i;
    live  = phi0_i && !m2sel_n_i;
    ready = !m_pend && !m_rec;
    rd    = (int'(cfg_slot_i) < NS) ? m_table[cfg_slot_i] : 0;
    new_owner = m_owner;
`ifdef SLOT_ROUTER_C8_OWNER_EN
    if (eoc && m_acc) begin
      if (m_cap >= 'hC100 && m_cap <= 'hC7FF && !intcxrom_i &&
          slot_on((m_cap - 'hC000) / 256))
        new_owner = (m_cap - 'hC000) / 256;
      if (m_cap == 'hCFFF) new_owner = 0;
    end
`endif
    wslot = -1; wcard = 0;
    if (m_rec) m_rec = 0;
    if (m_pend && eoc) begin
      wslot = m_pslot; wcard = m_pcard; m_pend = 0; m_rec = 1;
    end
    if (cfg_wr_i && ready && int'(cfg_slot_i) < NS) begin
      if (int'(cfg_slot_i) == sel && sel != 0) begin
        m_pend = 1; m_pslot = cfg_slot_i; m_pcard = cfg_card_i;
      end else begin
        wslot = cfg_slot_i; wcard = cfg_card_i;
      end
    end
    if (wslot >= 0) begin
      m_table[wslot] = wcard;
`ifdef SLOT_ROUTER_C8_OWNER_EN
      if (wcard == 0 && new_owner == wslot) new_owner = 0;
`endif
    end
    m_owner = new_owner;
    if (live) begin
      m_cap = int'(addr_i); m_acc = 1;
    end else if (eoc) begin
      m_acc = 0;
    end
    m_prev_phi0 = phi0_i;
    m_cfg_rd = rd;
  endfunction

  function automatic void push_expected();
    exp_t e;
    model_decode(e.sel, e.io_n, e.dev_n, e.stb_n);
    e.scard   = (e.sel != 0) ? m_table[e.sel] : 0;
    e.owner   = m_owner;
    e.rdy     = (!m_pend && !m_rec) ? 1 : 0;
    e.card_rd = m_cfg_rd;
    exp_q.push_back(e);
  endfunction

  task automatic applyStimulus(input bit r, input bit p, input bit m,
                               input logic [15:0] a, input bit cx, input bit c8,
                               input logic [2:0] cs, input bit w, input logic [7:0] cd);
    @(posedge clk_logic);
    #1;
    model_edge();
    reset = r; phi0_i = p; m2sel_n_i = m; addr_i = a;
    intcxrom_i = cx; intc8rom_i = c8;
    cfg_slot_i = cs; cfg_wr_i = w; cfg_card_i = cd;
    if (r) model_reset();
    push_expected();
  endtask

  task automatic busAccess(input logic [15:0] a, input bit cx, input bit c8,
                           input logic [2:0] cs, input bit w, input logic [7:0] cd);
    applyStimulus(0, 1, 0, a, cx, c8, cs, w, cd);
    applyStimulus(0, 1, 0, a, cx, c8, cs, 0, cd);
    applyStimulus(0, 0, 0, a, cx, c8, cs, 0, cd);
    applyStimulus(0, 0, 0, a, cx, c8, cs, 0, cd);
  endtask

  task automatic checkField(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("cfg_ready",   int'(cfg_ready_o),        e.rdy);
    checkField("cfg_card",    int'(cfg_card_o),         e.card_rd);
    checkField("slot_sel",    int'(slot_sel_o),         e.sel);
    checkField("slot_card",   int'(slot_card_o),        e.scard);
    checkField("ioselect_n",  int'(slot_ioselect_n_o),  e.io_n);
    checkField("devselect_n", int'(slot_devselect_n_o), e.dev_n);
    checkField("iostrobe_n",  int'(slot_iostrobe_n_o),  e.stb_n);
    checkField("c8_owner",    int'(c8_owner_o),         e.owner);
  endtask

  // monitor: compare each pushed expectation mid-cycle
  always @(negedge clk_logic) begin
    if (exp_q.size() != 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    logic [15:0] a;
    int          hi, lo, kind;
    bit          m, cx, c8, r, w;
    logic [7:0]  cd;

    model_reset();
    $display("[TB] reset and directed sequence");
    applyStimulus(1, 0, 1, 16'h0000, 0, 0, 3'd6, 0, 8'h00);
    applyStimulus(1, 0, 1, 16'h0000, 0, 0, 3'd6, 0, 8'h00);
    applyStimulus(0, 0, 1, 16'h0000, 0, 0, 3'd6, 0, 8'h00);
    applyStimulus(0, 0, 1, 16'h0000, 0, 0, 3'd6, 0, 8'h00);

    busAccess(16'hC600, 0, 0, 3'd6, 0, 8'h00);
    busAccess(16'hC800, 0, 0, 3'd6, 0, 8'h00);
    busAccess(16'hCFFF, 0, 0, 3'd6, 0, 8'h00);
    busAccess(16'hC800, 0, 0, 3'd6, 0, 8'h00);
    busAccess(16'hC0E3, 0, 0, 3'd6, 0, 8'h00);
    busAccess(16'hC600, 1, 0, 3'd6, 0, 8'h00);
    busAccess(16'hC800, 0, 0, 3'd6, 0, 8'h00);
    busAccess(16'hC600, 0, 0, 3'd6, 0, 8'h00);
    busAccess(16'hC655, 0, 0, 3'd6, 1, 8'h00);
    busAccess(16'hC600, 0, 0, 3'd6, 0, 8'h00);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 3'd6, 1, 8'h12);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 3'd7, 1, 8'h77);
    applyStimulus(0, 0, 0, 16'h0000, 0, 0, 3'd7, 0, 8'h00);
    busAccess(16'hC700, 0, 0, 3'd7, 0, 8'h00);
    busAccess(16'hC300, 0, 0, 3'd3, 0, 8'h00);
    applyStimulus(0, 1, 0, 16'hC310, 0, 0, 3'd3, 1, 8'h55);
    applyStimulus(1, 1, 0, 16'hC310, 0, 0, 3'd3, 0, 8'h00);
    applyStimulus(0, 0, 0, 16'hC310, 0, 0, 3'd3, 0, 8'h00);
    applyStimulus(0, 0, 0, 16'hC310, 0, 0, 3'd3, 0, 8'h00);

    $display("[TB] randomized sequence");
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0:       a = {8'hC0, 1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
        1:       a = {5'b11000, 3'($urandom_range(1, 7)), 8'($urandom_range(0, 255))};
        2:       a = 16'hC800 + 16'($urandom_range(0, 2046));
        3:       a = 16'hCFFF;
        4:       a = 16'($urandom_range(0, 65535));
        default: a = {8'hC0, 8'($urandom_range(0, 255))};
      endcase
      hi = $urandom_range(1, 3);
      lo = $urandom_range(1, 3);
      m  = ($urandom_range(0, 7) == 0);
      cx = ($urandom_range(0, 9) == 0);
      c8 = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < hi + lo; k++) begin
        r  = ($urandom_range(0, 299) == 0);
        w  = ($urandom_range(0, 3) == 0);
        cd = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        applyStimulus(r, k < hi, m, a, cx, c8, 3'($urandom_range(1, 7)), w, cd);
      end
    end

    applyStimulus(0, 0, 1, 16'h0000, 0, 0, 3'd0, 0, 8'h00);
    @(negedge clk_logic);
    #1;
    checkField("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
